// File: rtl/histo_region_scheduler_pkg.sv
// Shared SIFT descriptor definitions: window geometry, index widths and the
// region-scheduler state encoding used by extractor, scheduler and histogram.
package sift_desc_pkg;

  localparam int unsigned REGION_NUM = 9;
  localparam int unsigned PIX_NUM    = 89;
  localparam int unsigned REG_W      = $clog2(REGION_NUM);
  localparam int unsigned PIX_W      = $clog2(PIX_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD,
    S_DONE
  } hrs_state_e;

endpackage

// File: rtl/histo_region_scheduler_if.sv
// Control/handshake bundle between the region scheduler and the
// region mux / histogram datapath.
interface histo_region_scheduler_if;
  import sift_desc_pkg::*;

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [REG_W-1:0] reg_sel;
  logic [PIX_W-1:0] pix_sel;
  logic             hist_clr;
  logic             hist_en;
  logic             hist_valid;
  logic             hist_ready;

  modport master (
    output start, abort, hist_ready,
    input  busy, done, reg_sel, pix_sel, hist_clr, hist_en, hist_valid
  );

  modport slave (
    input  start, abort, hist_ready,
    output busy, done, reg_sel, pix_sel, hist_clr, hist_en, hist_valid
  );

endinterface

// File: rtl/histo_region_scheduler_term_counter.sv
// Up-counter with synchronous clear-load, enable and terminal-count flag;
// it saturates at TERM instead of wrapping.
module hrs_term_counter #(
  parameter int unsigned W    = 4,
  parameter int unsigned TERM = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  assign term = (cnt == TERM_V);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (en && !term) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/histo_region_scheduler.sv
// Sequences the descriptor regions of one keypoint window: clear, feed every
// pixel, wait out the histogram pipeline, then hold the result until accepted.
module histo_region_scheduler #(
  parameter int unsigned REGION_NUM = sift_desc_pkg::REGION_NUM,
  parameter int unsigned PIX_NUM    = sift_desc_pkg::PIX_NUM,
  parameter int unsigned PIPE_LAT   = 2
) (
  input logic                    clk,
  input logic                    rst,
  histo_region_scheduler_if.slave bus
);
  import sift_desc_pkg::*;

  localparam int unsigned RW        = $clog2(REGION_NUM);
  localparam int unsigned PW        = $clog2(PIX_NUM);
  localparam int unsigned DW        = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam int unsigned DRN_TERM  = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
  localparam logic [RW-1:0] REG_LAST = RW'(REGION_NUM - 1);

  hrs_state_e    state, state_next;
  logic [RW-1:0] region, region_next;

  logic [PW-1:0] pix_cnt;
  logic          pix_term, pix_load, pix_en;
  logic [DW-1:0] drn_cnt_unused;
  logic          drn_term, drn_load, drn_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      region <= '0;
    end else begin
      state  <= state_next;
      region <= region_next;
    end
  end

  always_comb begin
    state_next  = state;
    region_next = region;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next  = S_CLEAR;
          region_next = '0;
        end
      end
      S_CLEAR: state_next = S_FEED;
      S_FEED: begin
        if (pix_term) state_next = (PIPE_LAT == 0) ? S_HOLD : S_DRAIN;
      end
      S_DRAIN: begin
        if (drn_term) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (bus.hist_ready) begin
          if (region == REG_LAST) begin
            state_next = S_DONE;
          end else begin
            region_next = region + RW'(1);
            state_next  = S_CLEAR;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // abort overrides every other transition, including a pending increment
    if (bus.abort && state != S_IDLE) state_next = S_IDLE;
    if (state_next == S_IDLE) region_next = '0;
  end

  // counters sit at zero except while their own state is continuing
  assign pix_en   = (state == S_FEED);
  assign pix_load = (state != S_FEED) || (state_next != S_FEED);
  assign drn_en   = (state == S_DRAIN);
  assign drn_load = (state != S_DRAIN) || (state_next != S_DRAIN);

  hrs_term_counter #(.W(PW), .TERM(PIX_NUM - 1)) u_pix_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (pix_load),
    .en   (pix_en),
    .cnt  (pix_cnt),
    .term (pix_term)
  );

  hrs_term_counter #(.W(DW), .TERM(DRN_TERM)) u_drn_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (drn_load),
    .en   (drn_en),
    .cnt  (drn_cnt_unused),
    .term (drn_term)
  );

  assign bus.busy       = (state != S_IDLE) && (state != S_DONE);
  assign bus.done       = (state == S_DONE);
  assign bus.hist_clr   = (state == S_CLEAR);
  assign bus.hist_en    = (state == S_FEED);
  assign bus.hist_valid = (state == S_HOLD);
  assign bus.reg_sel    = REG_W'(region);
  assign bus.pix_sel    = PIX_W'(pix_cnt);

endmodule

// File: tb/tb_histo_region_scheduler.sv
// Bench for histo_region_scheduler: default build and a PIPE_LAT=0 build
// driven in lockstep against a window-schedule reference model.
module tb_histo_region_scheduler;

  localparam int NREG = 9;
  localparam int NPIX = 89;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st  = 1'b0;
  logic ab  = 1'b0;
  logic rd  = 1'b1;

  always #5 clk = ~clk;

  histo_region_scheduler_if bus0 ();
  histo_region_scheduler_if bus1 ();

  assign bus0.start      = st;
  assign bus0.abort      = ab;
  assign bus0.hist_ready = rd;
  assign bus1.start      = st;
  assign bus1.abort      = ab;
  assign bus1.hist_ready = rd;

  histo_region_scheduler #(.REGION_NUM(9), .PIX_NUM(89), .PIPE_LAT(2)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  histo_region_scheduler #(.REGION_NUM(9), .PIX_NUM(89), .PIPE_LAT(0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       clr;
    logic       en;
    logic       valid;
    logic [3:0] rs;
    logic [6:0] ps;
  } exp_t;

  // Reference: the full window as a list of per-cycle output records;
  // pos walks it, HOLD records repeat until hist_ready is seen.
  exp_t win [2][0:1023];
  int   wlen [2];
  int   pos  [2];

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;

  int done_at  [2];
  int valid_at [2];
  int clr_at;
  int hold3;

  function automatic exp_t mk(logic b, logic d, logic c, logic e, logic v, int r, int p);
    exp_t x;
    x = '{b, d, c, e, v, 4'(r), 7'(p)};
    return x;
  endfunction

  task automatic add(int k, exp_t e);
    win[k][wlen[k]] = e;
    wlen[k]++;
  endtask

  task automatic build(int k, int lat);
    wlen[k] = 0;
    for (int r = 0; r < NREG; r++) begin
      add(k, mk(1, 0, 1, 0, 0, r, 0));
      for (int p = 0; p < NPIX; p++) add(k, mk(1, 0, 0, 1, 0, r, p));
      for (int d = 0; d < lat; d++) add(k, mk(1, 0, 0, 0, 0, r, 0));
      add(k, mk(1, 0, 0, 0, 1, r, 0));
    end
    add(k, mk(0, 1, 0, 0, 0, NREG - 1, 0));
  endtask

  function automatic exp_t exp_now(int k);
    if (pos[k] < 0) return '0;
    return win[k][pos[k]];
  endfunction

  function automatic exp_t actual(int k);
    exp_t a;
    if (k == 0)
      a = '{bus0.busy, bus0.done, bus0.hist_clr, bus0.hist_en, bus0.hist_valid,
            bus0.reg_sel, bus0.pix_sel};
    else
      a = '{bus1.busy, bus1.done, bus1.hist_clr, bus1.hist_en, bus1.hist_valid,
            bus1.reg_sel, bus1.pix_sel};
    return a;
  endfunction

  task automatic model_step(int k);
    if (rst) begin
      pos[k] = -1;
    end else if (pos[k] < 0) begin
      if (st && !ab) pos[k] = 0;
    end else if (ab) begin
      pos[k] = -1;
    end else if (!(win[k][pos[k]].valid && !rd)) begin
      pos[k]++;
      if (pos[k] >= wlen[k]) pos[k] = -1;
    end
  endtask

  task automatic check_cycle(int k);
    exp_t a, e;
    a = actual(k);
    e = exp_now(k);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL outputs dut%0d cyc %0d: got busy=%b done=%b clr=%b en=%b valid=%b reg=%0d pix=%0d, want busy=%b done=%b clr=%b en=%b valid=%b reg=%0d pix=%0d",
               k, cyc, a.busy, a.done, a.clr, a.en, a.valid, a.rs, a.ps,
               e.busy, e.done, e.clr, e.en, e.valid, e.rs, e.ps);
    end
    nvec++;
    if ($countones({a.clr, a.en, a.valid}) > 1) begin
      nbad++;
      $display("FAIL onehot dut%0d cyc %0d: got clr/en/valid=%b%b%b, want at most one set",
               k, cyc, a.clr, a.en, a.valid);
    end
  endtask

  task automatic chk(string name, int got, int want);
    nvec++;
    if (got != want) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    check_cycle(0);
    check_cycle(1);
    for (int k = 0; k < 2; k++) begin
      if (actual(k).done && done_at[k] < 0) done_at[k] = cyc;
      if (actual(k).valid && valid_at[k] < 0) valid_at[k] = cyc;
    end
    if (bus0.hist_clr && clr_at < 0) clr_at = cyc;
    if (bus0.hist_valid && bus0.reg_sel == 4'd3) hold3++;
  endtask

  task automatic clear_marks();
    cyc         = 0;
    done_at[0]  = -1;
    done_at[1]  = -1;
    valid_at[0] = -1;
    valid_at[1] = -1;
    clr_at      = -1;
    hold3       = 0;
  endtask

  typedef struct {
    string name;
    int    stall_len;
    int    abort_at;
    int    rst_at;
    int    extra_start;
    int    exp_done0;
    int    exp_done1;
    int    exp_valid0;
    int    exp_valid1;
    int    exp_hold3;
  } scen_t;

  scen_t tbl [4];

  initial begin
    tbl[0] = '{"nominal",      0, -1,  -1,  -1, 838, 820, 93, 91,  1};
    tbl[1] = '{"stall_reg3",  10, -1,  -1,  -1, 848, 820, 93, 91, 11};
    tbl[2] = '{"abort_50",     0, 50,  -1,  -1,  -1,  -1, -1, -1,  0};
    tbl[3] = '{"rst_reg5",     0, -1, 500, 200,  -1,  -1, 93, 91,  1};

    build(0, 2);
    build(1, 0);
    pos[0] = -1;
    pos[1] = -1;
    clear_marks();

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int s = 0; s < 4; s++) begin
      clear_marks();
      for (int c = 0; c < 870; c++) begin
        st  = (cyc == 0) || (cyc == tbl[s].extra_start);
        ab  = (cyc == tbl[s].abort_at);
        rst = (cyc == tbl[s].rst_at);
        rd  = !(tbl[s].stall_len > 0 && cyc >= 372 && cyc < 372 + tbl[s].stall_len);
        tick();
      end
      st  = 1'b0;
      ab  = 1'b0;
      rst = 1'b0;
      rd  = 1'b1;
      chk({tbl[s].name, " first_clr"},  clr_at,      1);
      chk({tbl[s].name, " done0"},      done_at[0],  tbl[s].exp_done0);
      chk({tbl[s].name, " done1"},      done_at[1],  tbl[s].exp_done1);
      chk({tbl[s].name, " valid0"},     valid_at[0], tbl[s].exp_valid0);
      chk({tbl[s].name, " valid1"},     valid_at[1], tbl[s].exp_valid1);
      chk({tbl[s].name, " hold_reg3"},  hold3,       tbl[s].exp_hold3);
    end

    // abort and start together in idle: start is dropped
    st = 1'b1;
    ab = 1'b1;
    tick();
    st = 1'b0;
    ab = 1'b0;
    chk("abort_beats_start busy", int'(bus0.busy), 0);
    tick();
    chk("abort_beats_start clr", int'(bus0.hist_clr), 0);

    // randomized traffic against the model
    clear_marks();
    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(0, 799) == 0);
      ab  = ($urandom_range(0, 1499) == 0);
      st  = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/histo_region_scheduler.md
HISTO_REGION_SCHEDULER -- requirements
Module: histo_region_scheduler

Interface
REQ-001 Parameter REGION_NUM, default 9, number of descriptor regions per keypoint window.
REQ-002 Parameter PIX_NUM, default 89, pixels per circular region.
REQ-003 Parameter PIPE_LAT, default 2, cycles from last hist_en to histogram output stable; legal range 0..15.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to process one window.
REQ-007 abort  input  1  terminate current window, return to idle.
REQ-008 busy  output  1  high from the cycle after start is accepted until done or abort takes effect.
REQ-009 done  output  1  one-cycle pulse after the last region is accepted.
REQ-010 reg_sel  output  4  current region index, drives region mux select.
REQ-011 pix_sel  output  7  current pixel index within the region.
REQ-012 hist_clr  output  1  histogram clear strobe.
REQ-013 hist_en  output  1  histogram accumulate enable.
REQ-014 hist_valid  output  1  histogram of reg_sel complete and stable.
REQ-015 hist_ready  input  1  downstream accepts the histogram.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, HOLD, DONE.
REQ-017 IDLE: start=1 sampled on an edge -> CLEAR next cycle, region=0; start SHALL be ignored in any other state.
REQ-018 CLEAR: hist_clr=1 for exactly one cycle, pix counter=0 -> FEED.
REQ-019 FEED: hist_en=1 every cycle, pix_sel increments by 1 from 0 to PIX_NUM-1 with no gaps; after pix_sel=PIX_NUM-1 -> DRAIN, or HOLD directly if PIPE_LAT=0.
REQ-020 DRAIN: hist_en=0, stay exactly PIPE_LAT cycles -> HOLD.
REQ-021 HOLD: hist_valid=1, reg_sel held; hist_valid SHALL stay high until hist_ready=1 is sampled.
REQ-022 HOLD with hist_ready=1: if reg_sel=REGION_NUM-1 -> DONE, else reg_sel+1 and -> CLEAR.
REQ-023 DONE: done=1 one cycle -> IDLE; busy=0 in DONE.
REQ-024 hist_clr, hist_en, hist_valid SHALL be mutually exclusive in every cycle.
REQ-025 reg_sel and pix_sel SHALL be registered outputs, stable across FEED cycles except the defined increments; pix_sel=0 outside FEED.
REQ-026 abort=1 sampled in any non-IDLE state -> IDLE next cycle, no done pulse; abort has priority over hist_ready and counter terminal conditions.
REQ-027 abort and start in the same IDLE cycle: abort wins, start dropped.
REQ-028 Counter widths SHALL be $clog2 of REGION_NUM / PIX_NUM / PIPE_LAT+1; no wrap beyond terminal values.
REQ-029 With hist_ready tied high, one region SHALL take 1+PIX_NUM+PIPE_LAT+1 cycles (93 at defaults); full window 9*93+1=838 cycles from start edge to done.

Reset
REQ-030 rst=1 SHALL force IDLE, reg_sel=0, pix_sel=0, counters=0, and busy, done, hist_clr, hist_en, hist_valid=0 on the next edge.
REQ-031 rst SHALL override start, abort, hist_ready; reset mid-window discards the window with no done.

Structure
REQ-032 Shared package sift_desc_pkg SHALL hold REGION_NUM, PIX_NUM, index widths and the FSM state enum, shared with the region extractor and histogram blocks.
REQ-033 One sub-module hrs_term_counter (load/enable/terminal-count flag) SHALL be instanced for the pixel and drain counters; the region counter is inline.

Verification
REQ-034 start at cycle 0, hist_ready=1 -> hist_clr at 1, hist_en cycles 2..90 with pix_sel 0..88, hist_valid reg_sel=0 at 93, done at 838.
REQ-035 hist_ready=0 for 10 cycles during region 3 HOLD -> hist_valid held 11 cycles, reg_sel=3 stable, done delayed to 848.
REQ-036 abort at cycle 50 -> busy=0, hist_en=0 at 51, no done, subsequent start restarts at reg_sel=0.
REQ-037 rst during region 5 FEED -> all outputs 0 next cycle; start while busy (cycle 200) -> ignored, timing identical to REQ-034.
REQ-038 PIPE_LAT=0 build -> HOLD directly after pix_sel=88, region period 91 cycles; one-hot check of hist_clr/hist_en/hist_valid every cycle.
